imm_gen_pipe: RTL and testbench

//  Registered immediate generator for the decode stage; successor to the combinational extender.

---
 rtl/imm_gen_pipe_pkg.sv | 31 +++
 rtl/imm_gen_pipe_if.sv | 23 ++
 rtl/imm_gen_pipe_field_ext.sv | 43 ++++
 rtl/imm_gen_pipe.sv | 79 +++++++
 tb/tb_imm_gen_pipe.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared encodings for the registered immediate generator: extension modes,
// field widths, FSM states and the default prefix opcode.
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_Z5   = 3'd0,
    IMM_Z8   = 3'd1,
    IMM_S5   = 3'd2,
    IMM_S5B  = 3'd3,
    IMM_S8   = 3'd4,
    IMM_S8B  = 3'd5,
    IMM_S11  = 3'd6,
    IMM_S11B = 3'd7
  } imm_mode_e;

  localparam int FW5  = 5;
  localparam int FW8  = 8;
  localparam int FW11 = 11;

  localparam logic [4:0] PREFIX_OP_DEF = 5'b00001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } imm_state_e;

  function automatic logic mode_is_signed(input logic [2:0] sel);
    return (sel >= 3'd2);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side bus of the immediate generator: instruction in, stall/flush
// control, extended immediate and status out.
interface imm_gen_pipe_if #(parameter int DW = 16);
  logic          in_valid;
  logic [15:0]   in_instr;
  logic [2:0]    in_sel;
  logic          stall;
  logic          flush;
  logic          out_valid;
  logic [DW-1:0] out_imm;
  logic          out_pfx;
  logic          err;

  modport master (
    output in_valid, in_instr, in_sel, stall, flush,
    input  out_valid, out_imm, out_pfx, err
  );

  modport slave (
    input  in_valid, in_instr, in_sel, stall, flush,
    output out_valid, out_imm, out_pfx, err
  );
endinterface

// File: rtl/imm_gen_pipe_field_ext.sv
// Combinational field extraction and extension, optionally stacking an
// 11-bit prefix payload above the selected field.
module imm_field_ext
  import imm_gen_pipe_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [10:0]   instr_field,
  input  logic [2:0]    sel,
  input  logic [10:0]   payload,
  input  logic          pfx,
  output logic [DW-1:0] result
);

  logic          sgn;
  logic [DW-1:0] f5_ext, f8_ext, f11_ext;
  logic [DW-1:0] f5_zero, f8_zero, f11_zero;
  logic [DW-1:0] pay_ext;
  logic [DW-1:0] p5, p8, p11;

  always_comb begin
    sgn      = mode_is_signed(sel);
    f5_ext   = {{(DW-FW5){sgn & instr_field[4]}}, instr_field[4:0]};
    f8_ext   = {{(DW-FW8){sgn & instr_field[7]}}, instr_field[7:0]};
    f11_ext  = {{(DW-FW11){sgn & instr_field[10]}}, instr_field};
    f5_zero  = {{(DW-FW5){1'b0}}, instr_field[4:0]};
    f8_zero  = {{(DW-FW8){1'b0}}, instr_field[7:0]};
    f11_zero = {{(DW-FW11){1'b0}}, instr_field};
    pay_ext  = {{(DW-FW11){sgn & payload[10]}}, payload};
    // Shifting within DW bits drops payload MSBs for the wider fields.
    p5       = (pay_ext << FW5)  | f5_zero;
    p8       = (pay_ext << FW8)  | f8_zero;
    p11      = (pay_ext << FW11) | f11_zero;

    result = '0;
    case (imm_mode_e'(sel))
      IMM_Z5, IMM_S5, IMM_S5B: result = pfx ? p5 : f5_ext;
      IMM_Z8, IMM_S8, IMM_S8B: result = pfx ? p8 : f8_ext;
      default:                 result = pfx ? p11 : f11_ext;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with prefix instruction, stall and flush.
// Build option IMM_ERR_STICKY_EN: err latches on first double prefix until rst.
//
// state | meaning
// IDLE  | no prefix pending; next operand is extended on its own
// PEND  | prefix payload held; next non-prefix operand consumes it
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int         DW        = 16,
  parameter logic [4:0] PREFIX_OP = PREFIX_OP_DEF
) (
  input logic           clk,
  input logic           rst,
  imm_gen_pipe_if.slave bus
);

  imm_state_e    state;
  logic [10:0]   payload;
  logic          out_valid_q;
  logic [DW-1:0] out_imm_q;
  logic          out_pfx_q;
  logic          err_q;
  logic          is_prefix;
  logic [DW-1:0] ext_result;

  assign is_prefix = bus.in_valid && (bus.in_instr[15:11] == PREFIX_OP);

  imm_field_ext #(.DW(DW)) u_ext (
    .instr_field (bus.in_instr[10:0]),
    .sel         (bus.in_sel),
    .payload     (payload),
    .pfx         (state == ST_PEND),
    .result      (ext_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      payload     <= '0;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_pfx_q   <= 1'b0;
      err_q       <= 1'b0;
    end else if (!bus.stall) begin
`ifdef IMM_ERR_STICKY_EN
`else
      err_q <= 1'b0;
`endif
      if (bus.flush) begin
        state       <= ST_IDLE;
        payload     <= '0;
        out_valid_q <= 1'b0;
        out_pfx_q   <= 1'b0;
      end else if (bus.in_valid) begin
        if (is_prefix) begin
          if (state == ST_PEND) err_q <= 1'b1;
          state       <= ST_PEND;
          payload     <= bus.in_instr[10:0];
          out_valid_q <= 1'b0;
        end else begin
          state       <= ST_IDLE;
          payload     <= '0;
          out_valid_q <= 1'b1;
          out_imm_q   <= ext_result;
          out_pfx_q   <= (state == ST_PEND);
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_pfx   = out_pfx_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed operands push expected results,
// a negedge monitor pops and compares each fresh output.
module tb_imm_gen_pipe;

`ifdef IMM_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.DW(16)) bus ();

  imm_gen_pipe #(.DW(16), .PREFIX_OP(5'b00001)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [15:0] imm;
    logic        pfx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic st_q    = 1'b1;
  logic rst_q   = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] imm, input logic pfx);
    exp_t e;
    e.imm = imm;
    e.pfx = pfx;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic v, input logic [15:0] i, input logic [2:0] s,
                     input logic st = 1'b0, input logic fl = 1'b0);
    bus.in_valid = v;
    bus.in_instr = i;
    bus.in_sel   = s;
    bus.stall    = st;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0000, 3'd0);
  endtask

  always @(posedge clk) begin
    st_q  <= bus.stall;
    rst_q <= rst;
  end

  // Only outputs produced by a non-stalled, non-reset edge are fresh.
  always @(negedge clk) begin
    if (!rst_q && !st_q && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got imm %h pfx %b, expected none", bus.out_imm, bus.out_pfx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_imm", 32'(bus.out_imm), 32'(e.imm));
        chk("out_pfx", 32'(bus.out_pfx), 32'(e.pfx));
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_sel   = '0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_imm",   32'(bus.out_imm),   0);
    chk("rst_pfx",   32'(bus.out_pfx),   0);
    chk("rst_err",   32'(bus.err),       0);

    // Plain extension modes
    push(16'hFFFF, 1'b0); cyc(1'b1, 16'h001F, 3'd2);
    push(16'h00A5, 1'b0); cyc(1'b1, 16'h00A5, 3'd1);
    push(16'hFC00, 1'b0); cyc(1'b1, 16'h0400, 3'd6);
    push(16'hFF80, 1'b0); cyc(1'b1, 16'h0080, 3'd4);
    idle();

    // Prefix consumes no output slot
    cyc(1'b1, 16'h0FFF, 3'd5);
    chk("pfx_slot_valid", 32'(bus.out_valid), 0);
    push(16'hFFE3, 1'b1); cyc(1'b1, 16'h0003, 3'd2);
    cyc(1'b1, 16'h0801, 3'd0);
    push(16'h003F, 1'b1); cyc(1'b1, 16'h001F, 3'd0);

    // Wider prefixed modes drop payload MSBs
    cyc(1'b1, 16'h0FFF, 3'd0);
    push(16'hF801, 1'b1); cyc(1'b1, 16'h0001, 3'd6);
    cyc(1'b1, 16'h0801, 3'd0);
    push(16'h01FF, 1'b1); cyc(1'b1, 16'h00FF, 3'd4);
    cyc(1'b1, 16'h0FFF, 3'd0);
    push(16'hFF12, 1'b1); cyc(1'b1, 16'h0012, 3'd1);
    idle();

    // Stall while pending, then hold the result under stall
    cyc(1'b1, 16'h0801, 3'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 16'h001F, 3'd0, 1'b1);
      chk("stall_pend_valid", 32'(bus.out_valid), 0);
    end
    push(16'h003F, 1'b1); cyc(1'b1, 16'h001F, 3'd0);
    cyc(1'b0, 16'h0000, 3'd0, 1'b1);
    cyc(1'b1, 16'h00A5, 3'd1, 1'b1);
    chk("stall_hold_valid", 32'(bus.out_valid), 1);
    chk("stall_hold_imm",   32'(bus.out_imm),   32'h003F);
    idle();
    chk("idle_valid", 32'(bus.out_valid), 0);
    chk("idle_keep_imm", 32'(bus.out_imm), 32'h003F);

    // Flush drops the pending prefix and the in-flight operand
    cyc(1'b1, 16'h0FFF, 3'd0);
    cyc(1'b1, 16'h0003, 3'd2, 1'b0, 1'b1);
    chk("flush_valid", 32'(bus.out_valid), 0);
    push(16'h0003, 1'b0); cyc(1'b1, 16'h0003, 3'd2);
    chk("pre_dbl_err", 32'(bus.err), 0);

    // Double prefix
    cyc(1'b1, 16'h0801, 3'd0);
    cyc(1'b1, 16'h0FFF, 3'd0);
    chk("dbl_err", 32'(bus.err), 1);
    idle();
    chk("dbl_err_after", 32'(bus.err), 32'(STICKY));
    push(16'hFFE3, 1'b1); cyc(1'b1, 16'h0003, 3'd2);

    // Stall extends the err pulse
    cyc(1'b1, 16'h0FFF, 3'd0);
    cyc(1'b1, 16'h0801, 3'd0);
    cyc(1'b0, 16'h0000, 3'd0, 1'b1);
    chk("stall_err", 32'(bus.err), 1);
    push(16'h003F, 1'b1); cyc(1'b1, 16'h001F, 3'd0);
    chk("err_after_stall", 32'(bus.err), 32'(STICKY));
    cyc(1'b1, 16'h0801, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 3'd0, 1'b0, 1'b1);
    chk("err_after_flush", 32'(bus.err), 32'(STICKY));

    // Reset while pending clears everything and returns to IDLE
    cyc(1'b1, 16'h0FFF, 3'd0);
    rst = 1'b1;
    cyc(1'b1, 16'h0003, 3'd2, 1'b1, 1'b1);
    rst = 1'b0;
    chk("rst2_valid", 32'(bus.out_valid), 0);
    chk("rst2_imm",   32'(bus.out_imm),   0);
    chk("rst2_pfx",   32'(bus.out_pfx),   0);
    chk("rst2_err",   32'(bus.err),       0);
    push(16'h0003, 1'b0); cyc(1'b1, 16'h0003, 3'd2);

    idle();
    idle();
    idle();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
